// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes, ALUOp classes, funct3 values and the
// decoded-control payload carried from ID/EX into the ALU.
package alu_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned F3_W    = 3;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OP_W-1:0] OP_NOR = 4'b1100;

  localparam logic [ALUOP_W-1:0] ALUOP_MEM = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_I   = 2'b11;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [F3_W-1:0] F3_OR      = 3'b110;
  localparam logic [F3_W-1:0] F3_AND     = 3'b111;

  typedef struct packed {
    logic [OP_W-1:0] operation;
    logic            carry_in;
    logic            illegal;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct3/funct7[5] to ALU operation, carry-in and illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [F3_W-1:0]    funct3,
  input  logic               funct7_5,
  output logic [OP_W-1:0]    operation_c,
  output logic               carry_in_c,
  output logic               illegal_c
);

  always_comb begin
    operation_c = OP_ADD;
    carry_in_c  = 1'b0;
    illegal_c   = 1'b0;
    unique case (alu_op)
      ALUOP_MEM: ;
      ALUOP_BR: begin
        operation_c = OP_SUB;
        carry_in_c  = 1'b1;
      end
      default: begin
        // R and I share the funct3 map; only R-type honours funct7[5] for SUB
        unique case (funct3)
          F3_ADD_SUB: begin
            if (alu_op == ALUOP_R && funct7_5) begin
              operation_c = OP_SUB;
              carry_in_c  = 1'b1;
            end
          end
          F3_AND: operation_c = OP_AND;
          F3_OR:  operation_c = OP_OR;
          F3_SLT: begin
            operation_c = OP_SLT;
            carry_in_c  = 1'b1;
          end
          default: illegal_c = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_issue_stage.sv
// ID/EX boundary: decodes the ID bundle and holds it in a main + skid register
// pair with valid/ready handshakes, presenting registered ALU operands to EX.
module id_ex_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned N      = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned RD_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       rs1_data,
  input  logic [N-1:0]       rs2_data,
  input  logic [N-1:0]       imm,
  input  logic               alu_src,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [F3_W-1:0]    funct3,
  input  logic               funct7_5,
  input  logic [RD_W-1:0]    rd_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [OP_W-1:0]    alu_operation,
  output logic               alu_carry_in,
  output logic               illegal_op,
  output logic [RD_W-1:0]    rd_out,
  output logic [CTRL_W-1:0]  ctrl_out
);

  alu_ctrl_t         dec_c;
  logic [N-1:0]      b_sel_c;

  logic              skid_valid;
  logic [N-1:0]      skid_a;
  logic [N-1:0]      skid_b;
  alu_ctrl_t         skid_ctrl;
  logic [RD_W-1:0]   skid_rd;
  logic [CTRL_W-1:0] skid_pass;

  logic accept_c;
  logic transfer_c;
  logic load_main_in_c;
  logic load_main_skid_c;
  logic load_skid_c;
  logic out_valid_nxt_c;
  logic skid_valid_nxt_c;

  alu_op_decode u_decode (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .operation_c (dec_c.operation),
    .carry_in_c  (dec_c.carry_in),
    .illegal_c   (dec_c.illegal)
  );

  assign b_sel_c = alu_src ? imm : rs2_data;

  // Handshake bookkeeping; in_ready is registered so accept implies skid empty
  always_comb begin
    accept_c         = in_valid && in_ready;
    transfer_c       = out_valid && out_ready;
    load_main_in_c   = 1'b0;
    load_main_skid_c = 1'b0;
    load_skid_c      = 1'b0;
    out_valid_nxt_c  = out_valid;
    skid_valid_nxt_c = skid_valid;
    if (flush) begin
      out_valid_nxt_c  = 1'b0;
      skid_valid_nxt_c = 1'b0;
    end else if (transfer_c && skid_valid) begin
      load_main_skid_c = 1'b1;
      skid_valid_nxt_c = 1'b0;
    end else if (accept_c && (!out_valid || transfer_c)) begin
      load_main_in_c  = 1'b1;
      out_valid_nxt_c = 1'b1;
    end else if (accept_c) begin
      load_skid_c      = 1'b1;
      skid_valid_nxt_c = 1'b1;
    end else if (transfer_c) begin
      out_valid_nxt_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      out_valid  <= out_valid_nxt_c;
      skid_valid <= skid_valid_nxt_c;
      in_ready   <= !skid_valid_nxt_c;
    end
  end

  // Main entry drives the outputs directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a         <= '0;
      alu_b         <= '0;
      alu_operation <= OP_ADD;
      alu_carry_in  <= 1'b0;
      illegal_op    <= 1'b0;
      rd_out        <= '0;
      ctrl_out      <= '0;
    end else if (load_main_skid_c) begin
      alu_a         <= skid_a;
      alu_b         <= skid_b;
      alu_operation <= skid_ctrl.operation;
      alu_carry_in  <= skid_ctrl.carry_in;
      illegal_op    <= skid_ctrl.illegal;
      rd_out        <= skid_rd;
      ctrl_out      <= skid_pass;
    end else if (load_main_in_c) begin
      alu_a         <= rs1_data;
      alu_b         <= b_sel_c;
      alu_operation <= dec_c.operation;
      alu_carry_in  <= dec_c.carry_in;
      illegal_op    <= dec_c.illegal;
      rd_out        <= rd_in;
      ctrl_out      <= ctrl_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_a    <= '0;
      skid_b    <= '0;
      skid_ctrl <= '{operation: OP_ADD, carry_in: 1'b0, illegal: 1'b0};
      skid_rd   <= '0;
      skid_pass <= '0;
    end else if (load_skid_c) begin
      skid_a    <= rs1_data;
      skid_b    <= b_sel_c;
      skid_ctrl <= dec_c;
      skid_rd   <= rd_in;
      skid_pass <= ctrl_in;
    end
  end

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Bench for id_ex_issue_stage: directed scenarios plus random traffic checked
// against a queue model of the two-entry stage.
module tb_id_ex_issue_stage;

  localparam int unsigned N      = 64;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned RD_W   = 5;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      rs1_data;
  logic [N-1:0]      rs2_data;
  logic [N-1:0]      imm;
  logic              alu_src;
  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic              funct7_5;
  logic [RD_W-1:0]   rd_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      alu_a;
  logic [N-1:0]      alu_b;
  logic [3:0]        alu_operation;
  logic              alu_carry_in;
  logic              illegal_op;
  logic [RD_W-1:0]   rd_out;
  logic [CTRL_W-1:0] ctrl_out;

  typedef struct packed {
    logic [N-1:0]      a;
    logic [N-1:0]      b;
    logic [3:0]        op;
    logic              cin;
    logic              ill;
    logic [RD_W-1:0]   rd;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  id_ex_issue_stage #(.N(N), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_src(alu_src),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .rd_in(rd_in),
    .ctrl_in(ctrl_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_operation(alu_operation), .alu_carry_in(alu_carry_in),
    .illegal_op(illegal_op), .rd_out(rd_out), .ctrl_out(ctrl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the instruction table
  function automatic exp_t model_bundle();
    exp_t e;
    e.a    = rs1_data;
    e.b    = alu_src ? imm : rs2_data;
    e.rd   = rd_in;
    e.ctrl = ctrl_in;
    e.op   = 4'b0010;
    e.cin  = 1'b0;
    e.ill  = 1'b0;
    if (alu_op == 2'b01) begin
      e.op = 4'b0110; e.cin = 1'b1;
    end else if (alu_op[1]) begin
      if (funct3 == 3'b000) begin
        if (alu_op == 2'b10 && funct7_5) begin e.op = 4'b0110; e.cin = 1'b1; end
      end else if (funct3 == 3'b111) e.op = 4'b0000;
      else if (funct3 == 3'b110) e.op = 4'b0001;
      else if (funct3 == 3'b010) begin e.op = 4'b0111; e.cin = 1'b1; end
      else e.ill = 1'b1;
    end
    return e;
  endfunction

  // Advance model and clock by one edge; acc reports whether ID saw a handshake
  task automatic tick(output bit acc);
    exp_t e;
    acc = in_valid && (q.size() < 2);
    e = model_bundle();
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] im, input logic src,
                       input logic [RD_W-1:0] rd);
    in_valid = 1'b1; alu_op = op; funct3 = f3; funct7_5 = f7;
    rs1_data = a; rs2_data = b; imm = im; alu_src = src; rd_in = rd;
    ctrl_in = CTRL_W'(rd) ^ 8'hA5;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    bit acc;
    idle(); out_ready = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_operation !== 4'b0010 ||
        alu_a !== '0 || alu_b !== '0 || alu_carry_in !== 1'b0 ||
        illegal_op !== 1'b0 || rd_out !== '0 || ctrl_out !== '0) begin
      bad++;
      $display("FAIL reset_state: vld=%b rdy=%b op=%b a=%h b=%h cin=%b ill=%b rd=%0d ctrl=%h, want 0 1 0010 and zeros",
               out_valid, in_ready, alu_operation, alu_a, alu_b, alu_carry_in, illegal_op, rd_out, ctrl_out);
    end
    do_reset();
    // Fill both entries, then reset asynchronously between edges
    drive(2'b01, 3'b000, 1'b0, 64'h11, 64'h22, 64'h0, 1'b0, 5'd9);
    tick(acc);
    drive(2'b10, 3'b111, 1'b0, 64'h33, 64'h44, 64'h0, 1'b0, 5'd10);
    tick(acc);
    idle();
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill_before_reset: vld=%b rdy=%b, want 1 0", out_valid, in_ready);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_operation !== 4'b0010) begin
      bad++;
      $display("FAIL reset_midstream: vld=%b rdy=%b op=%b, want 0 1 0010",
               out_valid, in_ready, alu_operation);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    out_ready = 1'b1;
    tick(acc);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_drop: vld=%b after reset release, want 0", out_valid);
    end
  endtask

  task automatic test_sub();
    bit acc;
    out_ready = 1'b1;
    drive(2'b10, 3'b000, 1'b1, 64'h10, 64'h3, 64'h55, 1'b0, 5'd4);
    tick(acc);
    idle();
    total++;
    if (out_valid !== 1'b1 || alu_operation !== 4'b0110 || alu_carry_in !== 1'b1 ||
        alu_a !== 64'h10 || alu_b !== 64'h3 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL r_sub: vld=%b op=%b cin=%b a=%h b=%h ill=%b, want 1 0110 1 10 3 0",
               out_valid, alu_operation, alu_carry_in, alu_a, alu_b, illegal_op);
    end
    tick(acc);
  endtask

  task automatic test_addi();
    bit acc;
    out_ready = 1'b1;
    drive(2'b11, 3'b000, 1'b1, 64'h7, 64'h9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd5);
    tick(acc);
    idle();
    total++;
    if (out_valid !== 1'b1 || alu_operation !== 4'b0010 || alu_carry_in !== 1'b0 ||
        alu_b !== 64'hFFFF_FFFF_FFFF_FFFF || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL i_addi: vld=%b op=%b cin=%b b=%h ill=%b, want 1 0010 0 all-ones 0",
               out_valid, alu_operation, alu_carry_in, alu_b, illegal_op);
    end
    tick(acc);
  endtask

  task automatic test_illegal();
    bit acc;
    out_ready = 1'b1;
    drive(2'b10, 3'b001, 1'b0, 64'h1, 64'h2, 64'h0, 1'b0, 5'd6);
    tick(acc);
    idle();
    total++;
    if (out_valid !== 1'b1 || illegal_op !== 1'b1 || alu_operation !== 4'b0010 ||
        alu_carry_in !== 1'b0) begin
      bad++;
      $display("FAIL illegal_op: vld=%b ill=%b op=%b cin=%b, want 1 1 0010 0",
               out_valid, illegal_op, alu_operation, alu_carry_in);
    end
    tick(acc);
  endtask

  task automatic test_backpressure();
    bit acc;
    int idx;
    idx = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 3'b000, 1'b0, 64'(k), 64'(k + 100), 64'h0, 1'b0, RD_W'(idx + 1));
      tick(acc);
      if (acc) idx++;
    end
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd_out !== 5'd1 || idx != 2) begin
      bad++;
      $display("FAIL bp_full: rdy=%b vld=%b rd=%0d accepted=%0d, want 0 1 1 2",
               in_ready, out_valid, rd_out, idx);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || rd_out !== RD_W'(k + 1)) begin
        bad++;
        $display("FAIL bp_order%0d: vld=%b rd=%0d, want 1 %0d", k, out_valid, rd_out, k + 1);
      end
      if (idx < 3) drive(2'b00, 3'b000, 1'b0, 64'h3, 64'h103, 64'h0, 1'b0, 5'd3);
      else idle();
      tick(acc);
      if (acc) idx++;
      if (idx >= 3) idle();
    end
    total++;
    if (out_valid !== 1'b0 || idx != 3) begin
      bad++;
      $display("FAIL bp_drain: vld=%b accepted=%0d, want 0 3", out_valid, idx);
    end
  endtask

  task automatic test_flush();
    bit acc;
    out_ready = 1'b0;
    drive(2'b10, 3'b110, 1'b0, 64'hAA, 64'hBB, 64'h0, 1'b0, 5'd2);
    tick(acc);
    drive(2'b10, 3'b000, 1'b0, 64'hCC, 64'hDD, 64'h0, 1'b0, 5'd7);
    flush = 1'b1;
    tick(acc);
    idle();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(acc);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_leak: vld=%b rd=%0d, want no output", out_valid, rd_out);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    exp_t e;
    logic [2:0] f3s [0:5];
    f3s[0] = 3'b000; f3s[1] = 3'b111; f3s[2] = 3'b110;
    f3s[3] = 3'b010; f3s[4] = 3'b001; f3s[5] = 3'b101;
    idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      total++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        bad++;
        $display("FAIL rand_hs cyc%0d: vld=%b rdy=%b, want %b %b",
                 cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
      end else if (q.size() > 0) begin
        e = q[0];
        total++;
        if (alu_a !== e.a || alu_b !== e.b || alu_operation !== e.op ||
            alu_carry_in !== e.cin || illegal_op !== e.ill || rd_out !== e.rd ||
            ctrl_out !== e.ctrl) begin
          bad++;
          $display("FAIL rand_data cyc%0d: a=%h b=%h op=%b cin=%b ill=%b rd=%0d ctrl=%h, want %h %h %b %b %b %0d %h",
                   cyc, alu_a, alu_b, alu_operation, alu_carry_in, illegal_op, rd_out, ctrl_out,
                   e.a, e.b, e.op, e.cin, e.ill, e.rd, e.ctrl);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      alu_op    = 2'($urandom_range(0, 3));
      funct3    = f3s[$urandom_range(0, 5)];
      funct7_5  = 1'($urandom_range(0, 1));
      rs1_data  = {32'($urandom), 32'($urandom)};
      rs2_data  = {32'($urandom), 32'($urandom)};
      imm       = {32'($urandom), 32'($urandom)};
      alu_src   = 1'($urandom_range(0, 1));
      rd_in     = 5'($urandom);
      ctrl_in   = 8'($urandom);
      tick(acc);
    end
    idle();
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; alu_src = 1'b0; alu_op = '0;
    funct3 = '0; funct7_5 = 1'b0; rd_in = '0; ctrl_in = '0;
    #2;
    test_reset();
    test_sub();
    test_addi();
    test_illegal();
    test_backpressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
- ID/EX pipeline boundary that sits directly upstream of the 64-bit ripple-carry ALU.
- Accepts decoded instruction bundles from ID and buffers them in a 2-entry skid register with a valid/ready handshake.
- Translates ALUOp/funct3/funct7 into the ALU's 4-bit Operation code and carry-in, and selects operand B (rs2 or immediate).
- Presents ALU-ready operands plus pass-through control to EX.

Parameters:
N, 64, datapath width of operands and immediate
CTRL_W, 8, width of opaque pass-through control bundle (reg_write, mem_read, mem_write, mem_to_reg, etc.)
RD_W, 5, destination register index width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  ID presents a bundle
in_ready  output  1  stage can accept a bundle
rs1_data  input  N  operand A source
rs2_data  input  N  register operand B source
imm  input  N  sign-extended immediate
alu_src  input  1  1: B = imm, 0: B = rs2_data
alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
rd_in  input  RD_W  destination register
ctrl_in  input  CTRL_W  pass-through control
flush  input  1  discard all held bundles
out_valid  output  1  EX bundle valid
out_ready  input  1  EX consumes the bundle this cycle
alu_a  output  N  ALU operand A
alu_b  output  N  ALU operand B (after alu_src mux)
alu_operation  output  4  ALU Operation code
alu_carry_in  output  1  ALU carry-in
illegal_op  output  1  unsupported funct combination
rd_out  output  RD_W  destination register
ctrl_out  output  CTRL_W  pass-through control

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted, and after it, until the first accept:
  - out_valid=0; skid empty; in_ready=1.
  - alu_a, alu_b, rd_out, ctrl_out = 0; alu_operation=0010; alu_carry_in=0; illegal_op=0.
- Reset mid-operation drops both entries with no output.
- Decode is combinational on the input bundle and is captured into the entry, so outputs are purely registered.
- Decode table:
  - alu_op 00 -> ADD 0010, cin 0.
  - alu_op 01 -> SUB 0110, cin 1.
  - alu_op 10 (R-type):
    - f3=000, f7_5=0 -> ADD 0010, cin 0.
    - f3=000, f7_5=1 -> SUB 0110, cin 1.
    - f3=111 -> AND 0000, cin 0.
    - f3=110 -> OR 0001, cin 0.
    - f3=010 -> SLT 0111, cin 1.
  - alu_op 11 (I-type): same funct3 mapping, but f7_5 is ignored (000 is always ADD).
  - Any other combination -> ADD 0010, cin 0, illegal_op=1.
- Handshake:
  - Accept when in_valid && in_ready.
  - Transfer to EX when out_valid && out_ready.
  - in_ready = !skid_full, driven from a register.
- Main register:
  - Loads when empty, or when it transfers in the same cycle as an accept.
  - Otherwise an accept while the main register is held (out_valid && !out_ready) goes to the skid entry.
- Skid drain: when the main register transfers and the skid is full, the skid moves into main and the skid empties.
- Latency: an accepted bundle appears on the outputs the next cycle when the stage is empty.
- Throughput is 1 bundle per cycle while out_ready=1.
- Full: both entries valid -> in_ready=0. Bundles offered while full are not accepted and must be held by ID.
- Simultaneous accept and transfer with only main valid: the new bundle replaces main, out_valid stays 1, and the skid is untouched.
- Flush:
  - Next edge clears out_valid and the skid valid.
  - Flush has priority over any same-cycle accept, which is discarded.
  - in_ready=1 on the following cycle.
- Data fields hold their last values when invalid. Verification checks data only when out_valid=1.

Decomposition:
- Shared package alu_pkg:
  - Operation code constants: OP_AND=0000, OP_OR=0001, OP_ADD=0010, OP_SUB=0110, OP_SLT=0111, OP_NOR=1100.
  - ALUOp encodings: ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_I.
  - funct3 constants.
- One sub-module alu_op_decode: combinational alu_op/funct3/funct7_5 -> {operation, carry_in, illegal}, reused by the ALU testbench.

Test Plan:
- Reset mid-stream:
  - Stimulus: reset asserted with both entries full.
  - Required: out_valid=0, in_ready=1, alu_operation=0010 immediately (asynchronous).
- R-type SUB:
  - Stimulus: alu_op=10, f3=000, f7_5=1, rs1=0x10, rs2=0x3, alu_src=0, out_ready=1.
  - Required: next cycle alu_operation=0110, alu_carry_in=1, alu_a=0x10, alu_b=0x3.
- I-type ADDI:
  - Stimulus: alu_op=11, f3=000, f7_5=1, imm=0xFFFF_FFFF_FFFF_FFFF, alu_src=1.
  - Required: alu_operation=0010, cin=0, alu_b=all ones, illegal_op=0.
- Illegal op:
  - Stimulus: alu_op=10, f3=001.
  - Required: illegal_op=1, alu_operation=0010.
- Backpressure and skid order:
  - Stimulus: out_ready=0, three back-to-back bundles rd=1,2,3.
  - Required: rd=1 and rd=2 are accepted; in_ready=0 from the cycle after the rd=2 accept; rd=3 is held by ID.
  - Then out_ready=1: rd=1, 2, 3 emerge in order on consecutive cycles, with no loss or duplication.
- Flush vs accept:
  - Stimulus: flush=1 with in_valid=1 (rd=7) and main valid.
  - Required: next cycle out_valid=0; rd=7 is never emitted; in_ready=1.
